wb_pipe_stage: RTL and testbench

WB_PIPE_STAGE -- requirements
Module: wb_pipe_stage

---
 rtl/wb_pipe_stage.sv | 128 ++++++++++++
 tb/tb_wb_pipe_stage.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_pipe_stage.sv
// Two-entry in-order writeback buffer with retire counter.
// Optional sub-word load extension is enabled by defining WB_LOAD_EXT_EN.
module wb_pipe_stage #(
    parameter int WIDTH      = 16,
    parameter int DATA_WIDTH = 16,
    parameter int RF_WIDTH   = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      instrIn,
    input  logic [RF_WIDTH-1:0]   writeAddrIn,
    input  logic                  RFWriteEnIn,
    input  logic [DATA_WIDTH-1:0] aluResIn,
    input  logic [DATA_WIDTH-1:0] MEMReadData,
    input  logic                  LDSel,
    input  logic [1:0]            ldSize,
    input  logic                  ldSigned,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      instrOut,
    output logic [RF_WIDTH-1:0]   writeAddrOut,
    output logic                  RFWriteEnOut,
    output logic [DATA_WIDTH-1:0] aluResOut,
    output logic [CNT_WIDTH-1:0]  retireCount
);

    logic [1:0]            cnt_q, cnt_d;
    logic                  wptr_q, wptr_d;
    logic                  rptr_q, rptr_d;
    logic [CNT_WIDTH-1:0]  retire_q, retire_d;

    logic [WIDTH-1:0]      instr_q [2];
    logic [RF_WIDTH-1:0]   addr_q  [2];
    logic [1:0]            we_q;
    logic [DATA_WIDTH-1:0] data_q  [2];

    logic [DATA_WIDTH-1:0] ld_data;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  push;
    logic                  pop;

`ifdef WB_LOAD_EXT_EN
    always_comb begin
        ld_data = MEMReadData;
        case (ldSize)
            2'b00: ld_data = ldSigned ? DATA_WIDTH'($signed(MEMReadData[7:0]))
                                      : DATA_WIDTH'(MEMReadData[7:0]);
            2'b01: ld_data = ldSigned ? DATA_WIDTH'($signed(MEMReadData[15:0]))
                                      : DATA_WIDTH'(MEMReadData[15:0]);
            default: ld_data = MEMReadData;
        endcase
    end
`else
    logic unused_ld_ctrl;
    assign unused_ld_ctrl = ^{ldSize, ldSigned};
    assign ld_data        = MEMReadData;
`endif

    assign sel_data = LDSel ? ld_data : aluResIn;

    // Outputs are gated so that an empty buffer or held reset presents all zeros.
    assign in_ready  = reset & ~flush & (cnt_q != 2'd2);
    assign out_valid = reset & (cnt_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready & ~flush;

    assign instrOut     = out_valid ? instr_q[rptr_q] : '0;
    assign writeAddrOut = out_valid ? addr_q[rptr_q]  : '0;
    assign aluResOut    = out_valid ? data_q[rptr_q]  : '0;
    assign RFWriteEnOut = out_valid & we_q[rptr_q];
    assign retireCount  = retire_q;

    always_comb begin
        cnt_d    = cnt_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        retire_d = retire_q;
        if (flush) begin
            cnt_d  = '0;
            wptr_d = 1'b0;
            rptr_d = 1'b0;
        end else begin
            if (push) begin
                wptr_d = ~wptr_q;
            end
            if (pop) begin
                rptr_d = ~rptr_q;
                if (we_q[rptr_q]) begin
                    retire_d = retire_q + 1'b1;
                end
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 2'd1;
                2'b01:   cnt_d = cnt_q - 2'd1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q    <= '0;
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            retire_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            retire_q <= retire_d;
        end
    end

    // Payload storage needs no reset: it is only observed through cnt_q.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wptr_q] <= instrIn;
            addr_q[wptr_q]  <= writeAddrIn;
            we_q[wptr_q]    <= RFWriteEnIn;
            data_q[wptr_q]  <= sel_data;
        end
    end

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Self-checking bench for wb_pipe_stage: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_wb_pipe_stage;

    localparam int W   = 16;
    localparam int DW  = 16;
    localparam int RW  = 3;
    localparam int CW  = 4;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  instrIn;
    logic [RW-1:0] writeAddrIn;
    logic          RFWriteEnIn;
    logic [DW-1:0] aluResIn;
    logic [DW-1:0] MEMReadData;
    logic          LDSel;
    logic [1:0]    ldSize;
    logic          ldSigned;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  instrOut;
    logic [RW-1:0] writeAddrOut;
    logic          RFWriteEnOut;
    logic [DW-1:0] aluResOut;
    logic [CW-1:0] retireCount;

    wb_pipe_stage #(
        .WIDTH      (W),
        .DATA_WIDTH (DW),
        .RF_WIDTH   (RW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instrIn      (instrIn),
        .writeAddrIn  (writeAddrIn),
        .RFWriteEnIn  (RFWriteEnIn),
        .aluResIn     (aluResIn),
        .MEMReadData  (MEMReadData),
        .LDSel        (LDSel),
        .ldSize       (ldSize),
        .ldSigned     (ldSigned),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .instrOut     (instrOut),
        .writeAddrOut (writeAddrOut),
        .RFWriteEnOut (RFWriteEnOut),
        .aluResOut    (aluResOut),
        .retireCount  (retireCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          vld;
        logic [W-1:0]  instr;
        logic [RW-1:0] addr;
        logic          we;
        logic [DW-1:0] alu;
        logic [DW-1:0] mem;
        logic          ldsel;
        logic [1:0]    size;
        logic          sgn;
        logic          flush;
        logic          ordy;
    } stim_t;

    typedef struct {
        logic [W-1:0]  instr;
        logic [RW-1:0] addr;
        logic          we;
        logic [DW-1:0] data;
    } ent_t;

    ent_t  q[$];
    int    model_retire;
    stim_t cur;
    int    checks;
    int    failures;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Load data as the writeback would see it, derived from the extension rules.
    function automatic logic [DW-1:0] model_data(input stim_t s);
        int v;
        if (!s.ldsel) return s.alu;
`ifdef WB_LOAD_EXT_EN
        if (s.size == 2'b00) begin
            v = int'(s.mem) % 256;
            if (s.sgn && v >= 128) v = v - 256;
            return DW'(v);
        end
        if (s.size == 2'b01) begin
            v = int'(s.mem) % 65536;
            if (s.sgn && v >= 32768) v = v - 65536;
            return DW'(v);
        end
`endif
        return s.mem;
    endfunction

    function automatic stim_t idle(input logic ordy);
        stim_t s;
        s.rst = 1'b1; s.vld = 1'b0; s.instr = '0; s.addr = '0; s.we = 1'b0;
        s.alu = '0; s.mem = '0; s.ldsel = 1'b0; s.size = 2'b00; s.sgn = 1'b0;
        s.flush = 1'b0; s.ordy = ordy;
        return s;
    endfunction

    function automatic stim_t push_s(input logic [W-1:0] instr, input logic [RW-1:0] addr,
                                     input logic we, input logic [DW-1:0] alu, input logic ordy);
        stim_t s;
        s = idle(ordy);
        s.vld = 1'b1; s.instr = instr; s.addr = addr; s.we = we; s.alu = alu;
        return s;
    endfunction

    function automatic stim_t rand_s();
        stim_t s;
        s.rst   = ($urandom_range(0, 63) != 0);
        s.vld   = $urandom_range(0, 1) == 1;
        s.instr = W'($urandom);
        s.addr  = RW'($urandom);
        s.we    = $urandom_range(0, 3) != 0;
        s.alu   = DW'($urandom);
        s.mem   = DW'($urandom);
        s.ldsel = $urandom_range(0, 1) == 1;
        s.size  = 2'($urandom_range(0, 3));
        s.sgn   = $urandom_range(0, 1) == 1;
        s.flush = ($urandom_range(0, 15) == 0);
        s.ordy  = $urandom_range(0, 2) != 0;
        return s;
    endfunction

    // Apply inputs away from the rising edge and compare outputs with the model.
    task automatic drive(input stim_t s);
        logic exp_ov;
        @(negedge clk);
        cur         = s;
        reset       = s.rst;
        in_valid    = s.vld;
        instrIn     = s.instr;
        writeAddrIn = s.addr;
        RFWriteEnIn = s.we;
        aluResIn    = s.alu;
        MEMReadData = s.mem;
        LDSel       = s.ldsel;
        ldSize      = s.size;
        ldSigned    = s.sgn;
        flush       = s.flush;
        out_ready   = s.ordy;
        #1;
        exp_ov = s.rst && (q.size() > 0);
        check("out_valid", 64'(out_valid), 64'(exp_ov));
        check("in_ready", 64'(in_ready), 64'(s.rst && !s.flush && q.size() < 2));
        if (exp_ov) begin
            check("instrOut", 64'(instrOut), 64'(q[0].instr));
            check("writeAddrOut", 64'(writeAddrOut), 64'(q[0].addr));
            check("aluResOut", 64'(aluResOut), 64'(q[0].data));
            check("RFWriteEnOut", 64'(RFWriteEnOut), 64'(q[0].we));
        end else begin
            check("instrOut_idle", 64'(instrOut), 64'd0);
            check("writeAddrOut_idle", 64'(writeAddrOut), 64'd0);
            check("aluResOut_idle", 64'(aluResOut), 64'd0);
            check("RFWriteEnOut_idle", 64'(RFWriteEnOut), 64'd0);
        end
        check("retireCount", 64'(retireCount), 64'(model_retire));
    endtask

    task automatic commit();
        ent_t e;
        bit   can_push;
        @(posedge clk);
        if (!cur.rst) begin
            q.delete();
            model_retire = 0;
        end else if (cur.flush) begin
            q.delete();
        end else begin
            can_push = q.size() < 2;
            if (q.size() > 0 && cur.ordy) begin
                if (q[0].we) model_retire = (model_retire + 1) % (1 << CW);
                void'(q.pop_front());
            end
            if (cur.vld && can_push) begin
                e.instr = cur.instr; e.addr = cur.addr; e.we = cur.we; e.data = model_data(cur);
                q.push_back(e);
            end
        end
    endtask

    task automatic do_reset();
        stim_t s;
        s = idle(1'b0);
        s.rst = 1'b0;
        drive(s);
        commit();
    endtask

    initial begin
        stim_t s;
        int    saved_retire;
        checks = 0; failures = 0; model_retire = 0;
        reset = 1'b0; in_valid = 1'b0; instrIn = '0; writeAddrIn = '0; RFWriteEnIn = 1'b0;
        aluResIn = '0; MEMReadData = '0; LDSel = 1'b0; ldSize = 2'b00; ldSigned = 1'b0;
        flush = 1'b0; out_ready = 1'b0;
        cur = idle(1'b0);
        cur.rst = 1'b0;
        repeat (2) @(posedge clk);

        do_reset();

        // Single push, one-cycle latency, retire on pop.
        drive(push_s(16'h0039, 3'd5, 1'b1, 16'h1234, 1'b1)); commit();
        drive(idle(1'b1));
        check("d039_valid", 64'(out_valid), 64'd1);
        check("d039_data", 64'(aluResOut), 64'h1234);
        check("d039_we", 64'(RFWriteEnOut), 64'd1);
        commit();
        drive(idle(1'b0));
        check("d039_retire", 64'(retireCount), 64'd1);
        commit();

        // Back-pressure: two accepted, third held, in-order drain.
        drive(push_s(16'h00A1, 3'd1, 1'b1, 16'h1111, 1'b0)); commit();
        drive(push_s(16'h00B2, 3'd2, 1'b0, 16'h2222, 1'b0)); commit();
        drive(push_s(16'h00C3, 3'd3, 1'b1, 16'h3333, 1'b0));
        check("d040_full_ready", 64'(in_ready), 64'd0);
        commit();
        drive(idle(1'b1));
        check("d040_head0", 64'(instrOut), 64'h00A1);
        commit();
        drive(idle(1'b1));
        check("d040_head1", 64'(instrOut), 64'h00B2);
        commit();
        drive(idle(1'b0));
        check("d040_empty", 64'(out_valid), 64'd0);
        commit();

        // Simultaneous push and pop at one entry.
        drive(push_s(16'h00D4, 3'd4, 1'b1, 16'h4444, 1'b0)); commit();
        drive(push_s(16'h00E5, 3'd6, 1'b1, 16'h5555, 1'b1)); commit();
        drive(idle(1'b0));
        check("d041_nobubble", 64'(out_valid), 64'd1);
        check("d041_newhead", 64'(instrOut), 64'h00E5);
        commit();
        drive(idle(1'b1)); commit();

        // Byte load, signed then unsigned.
        s = push_s(16'h00F1, 3'd7, 1'b1, 16'hAAAA, 1'b1);
        s.ldsel = 1'b1; s.mem = 16'h00F0; s.size = 2'b00; s.sgn = 1'b1;
        drive(s); commit();
        s.instr = 16'h00F2; s.sgn = 1'b0;
        drive(s);
`ifdef WB_LOAD_EXT_EN
        check("d042_signed", 64'(aluResOut), 64'hFFF0);
`else
        check("d042_passthru", 64'(aluResOut), 64'h00F0);
`endif
        commit();
        drive(idle(1'b1));
        check("d042_unsigned", 64'(aluResOut), 64'h00F0);
        commit();

        // Flush with a full buffer.
        drive(push_s(16'h0101, 3'd1, 1'b1, 16'h0001, 1'b0)); commit();
        drive(push_s(16'h0202, 3'd2, 1'b1, 16'h0002, 1'b0)); commit();
        saved_retire = model_retire;
        s = idle(1'b1);
        s.flush = 1'b1;
        drive(s); commit();
        drive(idle(1'b0));
        check("d043_valid", 64'(out_valid), 64'd0);
        check("d043_ready", 64'(in_ready), 64'd1);
        check("d043_retire", 64'(retireCount), 64'(saved_retire));
        commit();

        // Counter wrap: 17 retiring writes on a 4-bit counter.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(push_s(W'(i), RW'(i), 1'b1, DW'(i * 3), 1'b1));
            commit();
        end
        drive(idle(1'b1)); commit();
        drive(idle(1'b0));
        check("d044_wrap", 64'(retireCount), 64'd1);
        commit();

        // Randomized traffic including occasional flush and reset.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            drive(rand_s());
            commit();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
